audvid_clock_color_i2s: RTL and testbench

- Audio/video support core for the AudVid peripheral, in a single clock domain.
- Derives the work clocks (master, SD, TFT, I2S bit clock) from the 100 MHz input.
- Decodes 4-bit tile colour codes into RGB565 pixels for the TFT SPI engine.
- Serialises 32-bit stereo samples ({left[15:0], right[15:0]}) onto an I2S DAC link.

---
 rtl/audvid_clock_color_i2s.sv | 92 +++++++++
 tb/tb_audvid_clock_color_i2s.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/audvid_clock_color_i2s.sv
// audvid_clock_color_i2s: AudVid work-clock dividers, RGB565 palette decoder and I2S DAC serialiser
//   CLK, Reset          100 MHz clock, async active-high reset
//   ColorInput/Output   4-bit palette index -> RGB565 colour (combinational)
//   InputData           {left[15:0], right[15:0]} sample, latched at each frame wrap
//   MasterCLK           CLK pass-through
//   SDCLK/TFTCLK/I2SCLK registered square-wave work clocks
//   I2S_CLK/DATA/WS     DAC link; SyncCLK pulses for one cycle when InputData is latched
module audvid_clock_color_i2s #(
    parameter int SD_DIV  = 8,
    parameter int TFT_DIV = 16,
    parameter int I2S_DIV = 76
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [3:0]  ColorInput,
    output logic [15:0] ColorOutput,
    input  logic [31:0] InputData,
    output logic        MasterCLK,
    output logic        SDCLK,
    output logic        TFTCLK,
    output logic        I2SCLK,
    output logic        I2S_CLK,
    output logic        I2S_DATA,
    output logic        I2S_WS,
    output logic        SyncCLK
);
    localparam int SdW  = $clog2(SD_DIV);
    localparam int TftW = $clog2(TFT_DIV);
    localparam int I2sW = $clog2(I2S_DIV);
    localparam logic [SdW-1:0]  SdLast  = SdW'(SD_DIV / 2 - 1);
    localparam logic [TftW-1:0] TftLast = TftW'(TFT_DIV / 2 - 1);
    localparam logic [I2sW-1:0] I2sLast = I2sW'(I2S_DIV / 2 - 1);
    localparam logic [15:0] Palette [16] = '{
        16'h0000, 16'h0015, 16'h0540, 16'h0555,
        16'hA800, 16'hA815, 16'hAAA0, 16'hAD55,
        16'h52AA, 16'h52BF, 16'h57EA, 16'h57FF,
        16'hFAAA, 16'hFABF, 16'hFFEA, 16'hFFFF
    };
    logic [SdW-1:0]  sdCnt;
    logic [TftW-1:0] tftCnt;
    logic [I2sW-1:0] i2sCnt;
    logic [4:0]      bitCnt, nextCnt, wsCnt;
    logic [31:0]     shiftReg;
    logic            i2sFall;
    assign ColorOutput = Palette[ColorInput];
    assign MasterCLK   = CLK;
    assign I2S_CLK     = I2SCLK;
    // the edge on which the bit clock is about to drop from 1 to 0
    assign i2sFall = I2SCLK && (i2sCnt == I2sLast);
    assign nextCnt = bitCnt + 5'd1;
    // WS leads the channel MSB by one bit, so it looks one position ahead
    assign wsCnt   = bitCnt + 5'd2;
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sdCnt  <= '0;
            tftCnt <= '0;
            i2sCnt <= '0;
            SDCLK  <= 1'b0;
            TFTCLK <= 1'b0;
            I2SCLK <= 1'b0;
        end else begin
            sdCnt  <= (sdCnt == SdLast) ? '0 : sdCnt + 1'b1;
            tftCnt <= (tftCnt == TftLast) ? '0 : tftCnt + 1'b1;
            i2sCnt <= (i2sCnt == I2sLast) ? '0 : i2sCnt + 1'b1;
            SDCLK  <= SDCLK ^ (sdCnt == SdLast);
            TFTCLK <= TFTCLK ^ (tftCnt == TftLast);
            I2SCLK <= I2SCLK ^ (i2sCnt == I2sLast);
        end
    end
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            bitCnt   <= 5'd31;
            shiftReg <= '0;
            I2S_DATA <= 1'b0;
            I2S_WS   <= 1'b0;
            SyncCLK  <= 1'b0;
        end else begin
            SyncCLK <= i2sFall && (bitCnt == 5'd31);
            if (i2sFall) begin
                bitCnt <= nextCnt;
                I2S_WS <= wsCnt[4];
                if (bitCnt == 5'd31) begin
                    shiftReg <= InputData;
                    I2S_DATA <= InputData[31];
                end else begin
                    // ~nextCnt == 31 - nextCnt: MSB first
                    I2S_DATA <= shiftReg[~nextCnt];
                end
            end
        end
    end
endmodule

// File: tb/tb_audvid_clock_color_i2s.sv
// tb_audvid_clock_color_i2s: randomized bench checking the AudVid core against a cycle-count model
`timescale 1ns/1ps
module tb_audvid_clock_color_i2s;
    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [3:0]  ColorInput = '0;
    logic [31:0] InputData = '0;
    logic [15:0] ColorOutput;
    logic        MasterCLK, SDCLK, TFTCLK, I2SCLK, I2S_CLK, I2S_DATA, I2S_WS, SyncCLK;

    audvid_clock_color_i2s dut (
        .CLK(CLK), .Reset(Reset), .ColorInput(ColorInput), .ColorOutput(ColorOutput),
        .InputData(InputData), .MasterCLK(MasterCLK), .SDCLK(SDCLK), .TFTCLK(TFTCLK),
        .I2SCLK(I2SCLK), .I2S_CLK(I2S_CLK), .I2S_DATA(I2S_DATA), .I2S_WS(I2S_WS),
        .SyncCLK(SyncCLK)
    );

    always #5 CLK = ~CLK;

    localparam logic [15:0] PAL [16] = '{
        16'h0000, 16'h0015, 16'h0540, 16'h0555,
        16'hA800, 16'hA815, 16'hAAA0, 16'hAD55,
        16'h52AA, 16'h52BF, 16'h57EA, 16'h57FF,
        16'hFAAA, 16'hFABF, 16'hFFEA, 16'hFFFF
    };

    int          t = 0;
    logic [31:0] word = '0;
    int          vecs = 0;
    int          errs = 0;
    bit          checking = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0d)", nm, act, exp, t);
        end
    endtask

    // a bit-clock fall at cycle n that starts a new frame (first at 76, then every 32 bits)
    function automatic bit isWrap(int n);
        return n >= 76 && n % 76 == 0 && ((n / 76 - 1) % 32) == 0;
    endfunction

    // model state: cycles since reset release, and the word latched at the last frame start
    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            t    <= 0;
            word <= '0;
        end else begin
            t <= t + 1;
            if (isWrap(t + 1)) word <= InputData;
        end
    end

    always @(negedge CLK) begin
        if (checking) begin
            int k, b;
            logic ed, ew;
            k  = t / 76;
            b  = (k - 1) % 32;
            ed = (k >= 1) ? word[31 - b] : 1'b0;
            ew = (k >= 1) ? (((b + 1) % 32) >= 16) : 1'b0;
            chk("master", {31'd0, MasterCLK}, {31'd0, CLK});
            chk("sdclk", {31'd0, SDCLK}, 32'((t / 4) % 2));
            chk("tftclk", {31'd0, TFTCLK}, 32'((t / 8) % 2));
            chk("i2sclk", {31'd0, I2SCLK}, 32'((t / 38) % 2));
            chk("i2s_clk", {31'd0, I2S_CLK}, 32'((t / 38) % 2));
            chk("i2s_data", {31'd0, I2S_DATA}, {31'd0, ed});
            chk("i2s_ws", {31'd0, I2S_WS}, {31'd0, ew});
            chk("sync", {31'd0, SyncCLK}, {31'd0, isWrap(t)});
            chk("color", {16'd0, ColorOutput}, {16'd0, PAL[ColorInput]});
        end
    end

    task automatic step(input int n, input bit rndData);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #2;
            ColorInput = 4'($urandom);
            if (rndData) InputData = $urandom;
        end
    endtask

    task automatic waitSync(input int lim, output int n);
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!SyncCLK && n < lim);
    endtask

    task automatic doReset();
        @(posedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        chk("reset_outs", {26'd0, SDCLK, TFTCLK, I2SCLK, I2S_DATA, I2S_WS, SyncCLK}, 32'd0);
        repeat (3) @(posedge CLK);
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        int n, w;
        logic prev;
        logic [31:0] cap, wsv;
        #1 Reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] e;
            e = PAL[i];
            ColorInput = 4'(i);
            #1;
            chk("color_sweep", {16'd0, ColorOutput}, {16'd0, e});
        end
        ColorInput = 4'd7;
        #1 chk("color7", {16'd0, ColorOutput}, 32'h0000AD55);
        ColorInput = 4'd12;
        #1 chk("color12", {16'd0, ColorOutput}, 32'h0000FAAA);
        #1 chk("reset_outs0", {26'd0, SDCLK, TFTCLK, I2SCLK, I2S_DATA, I2S_WS, SyncCLK}, 32'd0);
        InputData = 32'hA5A5_3C3C;
        repeat (2) @(posedge CLK);
        #2;
        Reset = 1'b0;
        checking = 1;
        waitSync(200, n);
        chk("first_sync", n, 76);
        cap = '0;
        wsv = '0;
        for (int i = 0; i < 32; i++) begin
            w = 0;
            do begin
                prev = I2SCLK;
                @(posedge CLK);
                #1;
                w++;
            end while (!(prev == 1'b0 && I2SCLK == 1'b1) && w < 100);
            if (w >= 100) chk("bitclk_timeout", w, 0);
            cap[31 - i] = I2S_DATA;
            wsv[i]      = I2S_WS;
        end
        chk("left_word", {16'd0, cap[31:16]}, 32'h0000A5A5);
        chk("right_word", {16'd0, cap[15:0]}, 32'h00003C3C);
        chk("ws_pattern", wsv, 32'h7FFF_8000);
        InputData = 32'hFFFF_0000;
        waitSync(200, n);
        step(300, 0);
        InputData = 32'h0000_FFFF;
        waitSync(2500, n);
        chk("frame_gap", n, 2132);
        step(2000, 1);
        waitSync(2500, n);
        step(10 * 76 + 20, 1);
        doReset();
        waitSync(200, n);
        chk("sync_after_reset", n, 76);
        step(2600, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
